seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 32 +++
 rtl/seq_divider.sv | 146 ++++++++++++++
 tb/tb_seq_divider.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// The partial remainder is N+1 bits wide; between steps it is always
// strictly smaller than the divisor, so its MSB is zero on entry.
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N:0] shifted_s;
    logic       ge_s;

    // Shift in the next dividend bit and subtract the divisor when it fits.
    // rem_in[N] is folded into the compare so an (unreachable) overflowed
    // remainder would still be treated as large enough to subtract from.
    always_comb begin
        shifted_s = {rem_in[N-1:0], bit_in};
        ge_s      = rem_in[N] | (shifted_s >= {1'b0, divisor});
        if (ge_s) begin
            rem_out = shifted_s - {1'b0, divisor};
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted_s;
            q_bit   = 1'b0;
        end
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential N-bit unsigned restoring divider.
// A start in IDLE captures the operands; N steps later (or one cycle later
// for a zero divisor) the results are loaded and done pulses for one cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = DIV_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quot,
    output logic [N-1:0] rem,
    output logic         div_by_zero
);

    localparam int            CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    // Architectural state and outputs
    div_state_t      state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N-1:0]    quot_q, quot_d;
    logic [N-1:0]    rem_q, rem_d;
    logic            dbz_q, dbz_d;

    // Working registers
    logic [N-1:0]    dvd_q, dvd_d;      // dividend, shifted out MSB-first
    logic [N-1:0]    dvs_q, dvs_d;      // captured divisor
    logic [N:0]      prem_q, prem_d;    // partial remainder
    logic [N-1:0]    qacc_q, qacc_d;    // quotient bits accumulated so far
    logic [CNT_W-1:0] cnt_q, cnt_d;     // number of steps already taken

    logic [N:0]      step_rem_s;
    logic            step_qbit_s;

    div_step #(.N(N)) u_step (
        .rem_in  (prem_q),
        .bit_in  (dvd_q[N-1]),
        .divisor (dvs_q),
        .rem_out (step_rem_s),
        .q_bit   (step_qbit_s)
    );

    // Next-state and output computation for the IDLE/CALC controller.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        qacc_d  = qacc_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = x;
                    dvs_d   = y;
                    prem_d  = '0;
                    qacc_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (dvs_q == '0) begin
                    // Zero divisor: saturate the quotient, pass x through.
                    quot_d  = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    prem_d = step_rem_s;
                    qacc_d = (qacc_q << 1) | N'(step_qbit_s);
                    dvd_d  = dvd_q << 1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        quot_d  = qacc_d;
                        rem_d   = step_rem_s[N-1:0];
                        dbz_d   = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            qacc_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            qacc_q  <= qacc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (N = 4).
module tb_seq_divider;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         busy;
    logic         done;
    logic [N-1:0] quot;
    logic [N-1:0] rem;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    // Last results the bench expects the outputs to be holding.
    logic [N-1:0] exp_q = '0;
    logic [N-1:0] exp_r = '0;
    logic         exp_z = 1'b0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .x           (x),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Called #1 after a clock edge; the next edge is the accepting edge k.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        x     = a;
        y     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_at_accept", 32'(busy), 32'd1);
    endtask

    // Waits (bounded) for done; outputs must hold the previous results meanwhile.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat  = 0;
        bit seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                check_eq({tag, "_busy"}, 32'(busy), 32'd1);
                check_eq({tag, "_hold_q"}, 32'(quot), 32'(exp_q));
                check_eq({tag, "_hold_r"}, 32'(rem), 32'(exp_r));
                check_eq({tag, "_hold_z"}, 32'(div_by_zero), 32'(exp_z));
            end
        end
        check_eq({tag, "_latency"}, seen ? 32'(lat) : 32'd99, 32'(exp_lat));
    endtask

    task automatic check_res(input string tag, input logic [N-1:0] q, input logic [N-1:0] r, input logic z);
        check_eq({tag, "_quot"}, 32'(quot), 32'(q));
        check_eq({tag, "_rem"}, 32'(rem), 32'(r));
        check_eq({tag, "_dbz"}, 32'(div_by_zero), 32'(z));
        check_eq({tag, "_busy_off"}, 32'(busy), 32'd0);
        exp_q = q;
        exp_r = r;
        exp_z = z;
    endtask

    // Main stimulus sequence
    initial begin
        rst   = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
        #1;
        rst = 1'b1;
        #11;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_quot", 32'(quot), 32'd0);
        check_eq("rst_rem", 32'(rem), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 13 / 3
        start_op(4'd13, 4'd3);
        wait_done("d13_3", 4);
        check_res("d13_3", 4'd4, 4'd1, 1'b0);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("quot_held", 32'(quot), 32'd4);

        // 7 / 0 then 6 / 2
        start_op(4'd7, 4'd0);
        wait_done("d7_0", 1);
        check_res("d7_0", 4'd15, 4'd7, 1'b1);
        @(posedge clk);
        #1;
        check_eq("dbz_done_one_cycle", 32'(done), 32'd0);
        start_op(4'd6, 4'd2);
        wait_done("d6_2", 4);
        check_res("d6_2", 4'd3, 4'd0, 1'b0);

        // Exhaustive sweep over non-zero divisors
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                start_op(N'(a), N'(b));
                wait_done("sweep", 4);
                check_res("sweep", N'(a / b), N'(a % b), 1'b0);
            end
        end

        // start held high during CALC is ignored
        x     = 4'd15;
        y     = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check_eq("hold_busy_at_accept", 32'(busy), 32'd1);
        x = 4'd2;
        y = 4'd2;
        wait_done("hold1", 4);
        check_res("hold1", 4'd15, 4'd0, 1'b0);
        // start still high in the done cycle: now it is taken
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("hold2_busy_at_accept", 32'(busy), 32'd1);
        wait_done("hold2", 4);
        check_res("hold2", 4'd1, 4'd0, 1'b0);

        // Back-to-back: second start issued in the done cycle
        start_op(4'd9, 4'd4);
        wait_done("b2b1", 4);
        check_res("b2b1", 4'd2, 4'd1, 1'b0);
        start_op(4'd10, 4'd5);
        wait_done("b2b2", 4);
        check_res("b2b2", 4'd2, 4'd0, 1'b0);

        // Reset two cycles into 14 / 3
        start_op(4'd14, 4'd3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_quot", 32'(quot), 32'd0);
        check_eq("abort_rem", 32'(rem), 32'd0);
        check_eq("abort_dbz", 32'(div_by_zero), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("abort_in_rst_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_eq("abort_no_done", 32'(done), 32'd0);
            check_eq("abort_idle_busy", 32'(busy), 32'd0);
        end
        exp_q = '0;
        exp_r = '0;
        exp_z = 1'b0;
        start_op(4'd14, 4'd3);
        wait_done("d14_3", 4);
        check_res("d14_3", 4'd4, 4'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_seq_divider
